// File: rtl/muldiv_hilo_ctrl_if.sv
// rtl/muldiv_hilo_ctrl_if.sv - EX-stage HI/LO request/response bundle for muldiv_hilo_ctrl
// Signals (pipeline -> controller):
//   ex_valid        EX stage holds a valid instruction
//   ex_op[7:0]      one-hot {mult,multu,div,divu,mfhi,mflo,mthi,mtlo}
//   ex_macc[3:0]    one-hot {madd,maddu,msub,msubu}
//   rs_val, rt_val  forwarded operands
//   flush           abort in-flight op, drop this cycle's request
// Signals (controller -> pipeline):
//   stall, busy, result, hi, lo
// Modports: master = pipeline side, slave = controller side
interface muldiv_hilo_ctrl_if;
  logic        ex_valid;
  logic [7:0]  ex_op;
  logic [3:0]  ex_macc;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output ex_valid, ex_op, ex_macc, rs_val, rt_val, flush,
    input  stall, busy, result, hi, lo
  );

  modport slave (
    input  ex_valid, ex_op, ex_macc, rs_val, rt_val, flush,
    output stall, busy, result, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// rtl/muldiv_hilo_ctrl.sv - MULT/MULTU/DIV/DIVU sequencer and owner of the HI/LO registers
// Parameters:
//   MUL_LAT   multiply latency in cycles (1..8)
//   HILO_RST  reset value of HI and LO
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   muldiv_hilo_ctrl_if.slave: ex_valid/ex_op/ex_macc/rs_val/rt_val/flush in,
//         stall (comb), busy (reg), result (comb from HI/LO), hi/lo (reg) out
// Build option: define MULDIV_MACC_EN to decode ex_macc (madd/maddu/msub/msubu).
module muldiv_hilo_ctrl #(
  parameter int unsigned MUL_LAT  = 3,
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input logic               clk,
  input logic               rst,
  muldiv_hilo_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q;
  logic [31:0] hi_q, lo_q;
  logic [63:0] product_q;
  logic [31:0] rem_q, quo_q, divisor_q;
  logic        neg_quo_q, neg_rem_q;

  logic op_mult, op_multu, op_div, op_divu, op_mfhi, op_mflo, op_mthi, op_mtlo;
  assign {op_mult, op_multu, op_div, op_divu, op_mfhi, op_mflo, op_mthi, op_mtlo} = bus.ex_op;

  logic        mul_req, div_req, macc_req, hilo_op, mul_signed;
  logic        busy, stall;
  logic [31:0] result;
  logic [63:0] mul_commit;

  assign mul_req = bus.ex_valid & (op_mult | op_multu) & ~bus.flush;
  assign div_req = bus.ex_valid & (op_div | op_divu) & ~bus.flush;

`ifdef MULDIV_MACC_EN
  logic acc_add_q, acc_sub_q;

  assign macc_req   = bus.ex_valid & (|bus.ex_macc) & ~bus.flush;
  assign hilo_op    = (|bus.ex_op) | (|bus.ex_macc);
  assign mul_signed = op_mult | bus.ex_macc[3] | bus.ex_macc[1];

  // Accumulate direction is captured at accept and applied at commit
  // against whatever HI/LO hold at that moment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_add_q <= 1'b0;
      acc_sub_q <= 1'b0;
    end else if (state_q == S_IDLE && !bus.flush) begin
      acc_add_q <= macc_req & (bus.ex_macc[3] | bus.ex_macc[2]);
      acc_sub_q <= macc_req & (bus.ex_macc[1] | bus.ex_macc[0]);
    end
  end

  always_comb begin
    mul_commit = product_q;
    if (acc_add_q)      mul_commit = {hi_q, lo_q} + product_q;
    else if (acc_sub_q) mul_commit = {hi_q, lo_q} - product_q;
  end

  assert property (@(posedge clk) disable iff (rst)
    bus.ex_valid |-> $onehot0({bus.ex_op, bus.ex_macc}));
`else
  logic unused_macc;
  assign unused_macc = ^bus.ex_macc;
  assign macc_req    = 1'b0;
  assign hilo_op     = |bus.ex_op;
  assign mul_signed  = op_mult;
  assign mul_commit  = product_q;

  assert property (@(posedge clk) disable iff (rst)
    bus.ex_valid |-> $onehot0(bus.ex_op));
`endif

  // Sign/zero extension to 64 bits makes one truncated multiply correct
  // for both signed and unsigned operands.
  logic [63:0] mul_a, mul_b;
  assign mul_a = {{32{mul_signed & bus.rs_val[31]}}, bus.rs_val};
  assign mul_b = {{32{mul_signed & bus.rt_val[31]}}, bus.rt_val};

  // The divider works on magnitudes; signs are restored in FIX.
  logic [31:0] abs_a, abs_b;
  assign abs_a = (op_div & bus.rs_val[31]) ? -bus.rs_val : bus.rs_val;
  assign abs_b = (op_div & bus.rt_val[31]) ? -bus.rt_val : bus.rt_val;

  // Restoring step: quo_q doubles as the dividend shift register, so its MSB
  // feeds the partial remainder and the new quotient bit enters at the LSB.
  // The remainder stays below the divisor, so 32 bits hold the difference.
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_next, quo_next;
  assign rem_sh   = {rem_q, quo_q[31]};
  assign rem_ge   = rem_sh >= {1'b0, divisor_q};
  assign rem_next = rem_ge ? (rem_sh[31:0] - divisor_q) : rem_sh[31:0];
  assign quo_next = {quo_q[30:0], rem_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mul_req || macc_req) state_d = S_MUL;
        else if (div_req)        state_d = S_DIV;
      end
      S_MUL:   if (count_q == 5'd0) state_d = S_IDLE;
      S_DIV:   if (count_q == 5'd0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    stall  = bus.ex_valid & hilo_op & busy & ~bus.flush;
    result = 32'h0;
    if (op_mfhi)      result = hi_q;
    else if (op_mflo) result = lo_q;
  end

  assign bus.busy   = busy;
  assign bus.stall  = stall;
  assign bus.result = result;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      hi_q      <= HILO_RST;
      lo_q      <= HILO_RST;
      product_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (bus.flush) begin
      // Abort wins over accept, commit and mthi/mtlo alike.
      count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mul_req || macc_req) begin
            product_q <= mul_a * mul_b;
            count_q   <= 5'(MUL_LAT - 1);
          end else if (div_req) begin
            rem_q     <= '0;
            quo_q     <= abs_a;
            divisor_q <= abs_b;
            neg_quo_q <= op_div & (bus.rs_val[31] ^ bus.rt_val[31]);
            neg_rem_q <= op_div & bus.rs_val[31];
            count_q   <= 5'd31;
          end else if (bus.ex_valid && op_mthi) begin
            hi_q <= bus.rs_val;
          end else if (bus.ex_valid && op_mtlo) begin
            lo_q <= bus.rs_val;
          end
        end
        S_MUL: begin
          if (count_q == 5'd0) {hi_q, lo_q} <= mul_commit;
          else                 count_q <= count_q - 5'd1;
        end
        S_DIV: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          if (count_q != 5'd0) count_q <= count_q - 5'd1;
        end
        S_FIX: begin
          lo_q <= neg_quo_q ? -quo_q : quo_q;
          hi_q <= neg_rem_q ? -rem_q : rem_q;
        end
        default: ;
      endcase
    end
  end

endmodule
